addi3_prog_loader: RTL
======================

ADDI3_PROG_LOADER -- requirements
Module: addi3_prog_loader

Interface
REQ-001 SHALL have parameter MAX_INST, default 64, giving the maximum number of instructions per program (1..256).
REQ-002 SHALL have the following ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start-load pulse; sampled only in IDLE.
- base_addr  in  32  first instruction address; latched on accepted go.
- run_cycles  in  16  core run length; latched on accepted go.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  loader can accept a request.
- in_rd  in  5  destination register.
- in_a, in_b, in_c  in  5 each  the three unsigned immediates.
- in_last  in  1  marks the final request of a program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  32  write address.
- imem_wdata  out  32  encoded ADDI3 word.
- tb_start  out  1  core start/run enable.
- init_inst_addr  out  32  core initial PC.
- exp_valid  out  1  expected-result pulse.
- exp_rd  out  5  expected-result register.
- exp_value  out  7  expected-result value.
- inst_count  out  9  instructions written this program.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  run finished.

Function
REQ-003 SHALL implement the FSM states IDLE, LOAD, WRITE, START, RUN and DONE.
REQ-004 In IDLE, go=1 SHALL latch base_addr and run_cycles, clear inst_count, and move to LOAD.
REQ-005 In LOAD, in_ready SHALL be 1; in_valid=1 SHALL latch rd, a, b, c and last, then move to WRITE.
REQ-006 In every state other than LOAD, in_ready SHALL be 0; requests SHALL be neither lost nor duplicated under backpressure.
REQ-007 WRITE SHALL last exactly 1 cycle, with the following outputs:
- imem_we=1.
- imem_addr = latched base + 4*inst_count, modulo 2^32.
- imem_wdata = {2'b01, a, b, c, 3'b100, rd, 7'b0000010}.
REQ-008 In the WRITE cycle, exp_valid SHALL be 1, exp_rd SHALL equal rd, and exp_value SHALL be a+b+c (7-bit, no overflow possible, max 93).
REQ-009 When rd=0, exp_value SHALL be 0 (x0 hardwired), while imem_wdata SHALL still be encoded and written.
REQ-010 At the end of WRITE, inst_count SHALL increment; the next state SHALL be START if last=1 or the new inst_count equals MAX_INST, else LOAD.
REQ-011 START SHALL last 1 cycle with tb_start=0 and init_inst_addr = latched base, then move to RUN.
REQ-012 RUN SHALL hold tb_start=1 and init_inst_addr = latched base for max(run_cycles,1) cycles, then move to DONE.
REQ-013 DONE SHALL drive done=1 and tb_start=0 and hold inst_count; go=1 SHALL restart as in REQ-004, with done falling the next cycle.
REQ-014 go SHALL be ignored in LOAD, WRITE, START and RUN.
REQ-015 imem_we and exp_valid SHALL be 0 outside WRITE; imem_addr, imem_wdata, exp_rd and exp_value SHALL be 0 outside WRITE.
REQ-016 init_inst_addr SHALL be 0 outside START and RUN.
REQ-017 All outputs SHALL be registered or decoded purely from the registered state; no combinational path from in_valid to in_ready.

Reset
REQ-018 rst=1 SHALL, on the next edge, force IDLE and clear inst_count and all latched fields.
REQ-019 During rst=1, every output SHALL be 0, including in_ready, tb_start, done and busy.
REQ-020 rst SHALL take priority over go, in_valid and any in-progress WRITE or RUN; no imem_we SHALL occur in the reset cycle.

Verification
REQ-021 SHALL run the following directed scenarios:
- Encoding: base=0; requests (1,9,3,4), (2,2,3,7), (3,1,2,3,last) -> imem writes 0x00:0x52324082, 0x04:0x4433C102, 0x08:0x4221C182; exp (1,16), (2,12), (3,6); inst_count=3.
- Run timing: run_cycles=5 -> tb_start 0 for 1 cycle with init_inst_addr=base, then 1 for exactly 5 cycles, then done=1.
- x0 and run_cycles=0: request (0,31,31,31,last) -> wdata 0x7FFFC002, exp_value=0; run_cycles=0 gives a 1-cycle RUN.
- Capacity and wrap: MAX_INST=4, 6 requests without last, base=0xFFFFFFF8 -> 4 writes at FFFFFFF8, FFFFFFFC, 00000000, 00000004, then START; in_ready=0 after the fourth write.
- Backpressure: in_valid held high continuously -> exactly one write per LOAD/WRITE pair (2-cycle spacing), no duplicates.
- Reset mid-operation: rst during WRITE and during RUN -> next cycle all outputs 0, state IDLE; a subsequent go reloads from inst_count=0.

Source files
------------

// File: rtl/addi3_prog_loader.sv
// ADDI3 program loader: accepts instruction requests, encodes and writes them
// into instruction memory, publishes the expected register result of each
// instruction, then starts the core for a programmable number of cycles.
module addi3_prog_loader #(
    parameter int unsigned MAX_INST = 64  // 1..256 instructions per program
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [31:0] base_addr,
    input  logic [15:0] run_cycles,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_a,
    input  logic [4:0]  in_b,
    input  logic [4:0]  in_c,
    input  logic        in_last,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        tb_start,
    output logic [31:0] init_inst_addr,
    output logic        exp_valid,
    output logic [4:0]  exp_rd,
    output logic [6:0]  exp_value,
    output logic [8:0]  inst_count,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_START,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [8:0] MAX_CNT = 9'(MAX_INST);

    state_e      state_q,      state_d;
    logic [31:0] base_q,       base_d;
    logic [15:0] run_cycles_q, run_cycles_d;
    logic [15:0] run_cnt_q,    run_cnt_d;
    logic [8:0]  inst_count_q, inst_count_d;
    logic [4:0]  rd_q,         rd_d;
    logic [4:0]  a_q,          a_d;
    logic [4:0]  b_q,          b_d;
    logic [4:0]  c_q,          c_d;
    logic        last_q,       last_d;

    logic [8:0]  inst_next;
    logic [15:0] run_last;

    // A zero run length still yields one RUN cycle.
    assign inst_next = inst_count_q + 9'd1;
    assign run_last  = (run_cycles_q == 16'd0) ? 16'd0 : run_cycles_q - 16'd1;

    // State and latched-field registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            run_cycles_q <= '0;
            run_cnt_q    <= '0;
            inst_count_q <= '0;
            rd_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            run_cycles_q <= run_cycles_d;
            run_cnt_q    <= run_cnt_d;
            inst_count_q <= inst_count_d;
            rd_q         <= rd_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            last_q       <= last_d;
        end
    end

    // Next-state and latched-field update logic.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d      = state_q;
        base_d       = base_q;
        run_cycles_d = run_cycles_q;
        run_cnt_d    = run_cnt_q;
        inst_count_d = inst_count_q;
        rd_d         = rd_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        last_d       = last_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    base_d       = base_addr;
                    run_cycles_d = run_cycles;
                    inst_count_d = '0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    rd_d    = in_rd;
                    a_d     = in_a;
                    b_d     = in_b;
                    c_d     = in_c;
                    last_d  = in_last;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                inst_count_d = inst_next;
                state_d      = (last_q || (inst_next == MAX_CNT)) ? S_START : S_LOAD;
            end
            S_START: begin
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (run_cnt_q == run_last) begin
                    state_d = S_DONE;
                end else begin
                    run_cnt_d = run_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state; everything is forced low while rst is high.
    always_comb begin
        in_ready       = 1'b0;
        imem_we        = 1'b0;
        imem_addr      = '0;
        imem_wdata     = '0;
        tb_start       = 1'b0;
        init_inst_addr = '0;
        exp_valid      = 1'b0;
        exp_rd         = '0;
        exp_value      = '0;
        inst_count     = '0;
        busy           = 1'b0;
        done           = 1'b0;

        if (!rst) begin
            inst_count = inst_count_q;
            busy       = (state_q != S_IDLE) && (state_q != S_DONE);
            unique case (state_q)
                S_LOAD: in_ready = 1'b1;
                S_WRITE: begin
                    imem_we    = 1'b1;
                    imem_addr  = base_q + {21'd0, inst_count_q, 2'b00};
                    imem_wdata = {2'b01, a_q, b_q, c_q, 3'b100, rd_q, 7'b0000010};
                    exp_valid  = 1'b1;
                    exp_rd     = rd_q;
                    // x0 is hardwired to zero, so its expected value is zero.
                    exp_value  = (rd_q == 5'd0) ? 7'd0
                               : ({2'b00, a_q} + {2'b00, b_q} + {2'b00, c_q});
                end
                S_START: init_inst_addr = base_q;
                S_RUN: begin
                    tb_start       = 1'b1;
                    init_inst_addr = base_q;
                end
                S_DONE: done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
